// File: rtl/uart_rx_cfg_if.sv
// Receive-side word interface of uart_rx_cfg.
// master: receiver drives the held word and flags, consumer drives rx_ready and err_clear.
interface uart_rx_cfg_if #(
    parameter int DATA_W = 9
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              parity_error;
    logic              framing_error;
    logic              break_detect;
    logic              overrun_error;
    logic              err_clear;

    modport master (
        output rx_data, rx_valid, parity_error,
        output framing_error, break_detect, overrun_error,
        input  rx_ready, err_clear
    );

    modport slave (
        input  rx_data, rx_valid, parity_error,
        input  framing_error, break_detect, overrun_error,
        output rx_ready, err_clear
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: tick-oversampled, 3-sample majority vote, 5..DATA_W data
// bits, none/even/odd parity, 1/2 stop bits, break/framing/overrun flags.
// Ports: clk, reset_n (async, active low), rx (async serial line), sample_tick
// (OVERSAMPLE pulses per bit), data_bits/parity_mode/stop_bits (frame format),
// bus (master side: held word, valid/ready, per-word flags, sticky overrun, err_clear).
module uart_rx_cfg #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       sample_tick,
    input  logic [3:0] data_bits,
    input  logic [1:0] parity_mode,
    input  logic       stop_bits,
    uart_rx_cfg_if.master bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [CW-1:0] C_LO  = CW'(M - 1);
    localparam logic [CW-1:0] C_MID = CW'(M);
    localparam logic [CW-1:0] C_HI  = CW'(M + 1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DW4   = 4'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // 2-flop synchroniser, idles high so reset does not look like a start bit
    logic [1:0] sync;
    logic       rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= 2'b11;
        else          sync <= {sync[0], rx};
    end

    assign rx_s = sync[1];

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [1:0]        smp;
    logic              armed;
    logic [3:0]        n_q;
    logic [1:0]        pm_q;
    logic              two_q;
    logic [3:0]        bit_idx;
    logic              stop_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_q;
    logic              ferr_q;
    logic              zero_q;

    logic [DATA_W-1:0] data_q;
    logic              vld_q;
    logic              pe_q;
    logic              fe_q;
    logic              bk_q;
    logic              ovr_q;

    logic       vote;
    logic       at_vote;
    logic       at_end;
    logic       par_en;
    logic       last_stop;
    logic       done;
    logic       fr_err;
    logic       fr_brk;
    logic       fr_perr;
    logic [3:0] n_clamp;

    always_comb begin
        vote      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
        at_vote   = sample_tick && (cnt == C_HI);
        at_end    = sample_tick && (cnt == C_END);
        par_en    = (pm_q == 2'b01) || (pm_q == 2'b10);
        last_stop = !two_q || stop_idx;
        done      = at_vote && (state == STOP) && last_stop;
        fr_err    = ferr_q | ~vote;
        fr_brk    = zero_q & ~vote;
        // shreg holds only the latched data bits, so its XOR is the data parity
        fr_perr   = par_en & (par_q ^ (^shreg) ^ pm_q[1]);
        n_clamp   = data_bits;
        if (data_bits < 4'd5) n_clamp = 4'd5;
        else if (data_bits > DW4) n_clamp = DW4;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            smp      <= '0;
            armed    <= 1'b0;
            n_q      <= '0;
            pm_q     <= '0;
            two_q    <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_q    <= 1'b0;
            ferr_q   <= 1'b0;
            zero_q   <= 1'b0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            bk_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (sample_tick && state != IDLE) begin
                cnt <= (cnt == C_END) ? '0 : cnt + CW'(1);
                if (cnt == C_LO)  smp[0] <= rx_s;
                if (cnt == C_MID) smp[1] <= rx_s;
            end

            unique case (state)
                IDLE: begin
                    if (sample_tick) begin
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state    <= START;
                            cnt      <= '0;
                            n_q      <= n_clamp;
                            pm_q     <= parity_mode;
                            two_q    <= stop_bits;
                            bit_idx  <= '0;
                            stop_idx <= 1'b0;
                            shreg    <= '0;
                            par_q    <= 1'b0;
                            ferr_q   <= 1'b0;
                            zero_q   <= 1'b1;
                        end
                    end
                end
                START: begin
                    if (at_vote && vote) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (at_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_vote) begin
                        shreg  <= shreg | (DATA_W'(vote) << bit_idx);
                        zero_q <= zero_q & ~vote;
                    end
                    if (at_end) begin
                        if (bit_idx == n_q - 4'd1)
                            state <= par_en ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 4'd1;
                    end
                end
                PARITY: begin
                    if (at_vote) begin
                        par_q  <= vote;
                        zero_q <= zero_q & ~vote;
                    end
                    if (at_end) state <= STOP;
                end
                STOP: begin
                    if (at_vote) begin
                        if (last_stop) begin
                            // finish mid stop bit to catch a back-to-back start
                            state <= IDLE;
                            cnt   <= '0;
                            armed <= 1'b0;
                        end else begin
                            ferr_q <= fr_err;
                            zero_q <= fr_brk;
                        end
                    end else if (at_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.err_clear) ovr_q <= 1'b0;

            if (done) begin
                if (!vld_q || bus.rx_ready) begin
                    data_q <= shreg;
                    pe_q   <= fr_perr;
                    fe_q   <= fr_err;
                    bk_q   <= fr_brk;
                    vld_q  <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (vld_q && bus.rx_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = vld_q;
    assign bus.parity_error  = pe_q;
    assign bus.framing_error = fe_q;
    assign bus.break_detect  = bk_q;
    assign bus.overrun_error = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: directed and random frames, scoreboard-checked.
// Expected words come from a frame-level model of the serial format.
module tb_uart_rx_cfg;
    localparam int OS      = 16;
    localparam int DW      = 9;
    localparam int TDIV    = 4;
    localparam int BIT_CLK = OS * TDIV;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic       sample_tick;
    logic [3:0] data_bits;
    logic [1:0] parity_mode;
    logic       stop_bits;

    uart_rx_cfg_if #(.DATA_W(DW)) bus ();

    uart_rx_cfg #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .sample_tick(sample_tick),
        .data_bits  (data_bits),
        .parity_mode(parity_mode),
        .stop_bits  (stop_bits),
        .bus        (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          fe;
        logic          bk;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   n_words = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (TDIV - 1) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int eff_n(input int raw);
        if (raw < 5) return 5;
        if (raw > DW) return DW;
        return raw;
    endfunction

    function automatic bit good_par(input int raw, input int pm, input int data);
        int w = data & ((1 << eff_n(raw)) - 1);
        return bit'($countones(w) % 2) ^ (pm == 2);
    endfunction

    function automatic exp_t model(input int raw, input int pm, input bit two,
                                   input int data, input bit pbit,
                                   input bit s0, input bit s1);
        exp_t r;
        int   w   = data & ((1 << eff_n(raw)) - 1);
        bit   pen = (pm == 1) || (pm == 2);
        r.data = DW'(w);
        r.pe   = pen && (pbit != good_par(raw, pm, data));
        r.fe   = !s0 || (two && !s1);
        r.bk   = (w == 0) && (!pen || !pbit) && !s0 && (!two || !s1);
        return r;
    endfunction

    task automatic frame(input int raw, input int pm, input bit two,
                         input int data, input bit flip, input bit s0,
                         input bit s1, input bit push, input int maxbits,
                         input int spike, input bit scramble);
        bit line[$];
        bit pen = (pm == 1) || (pm == 2);
        bit pb  = good_par(raw, pm, data) ^ flip;
        data_bits   = 4'(raw);
        parity_mode = 2'(pm);
        stop_bits   = two;
        if (push) sb.push_back(model(raw, pm, two, data, pb, s0, s1));
        line.push_back(1'b0);
        for (int i = 0; i < eff_n(raw); i++) line.push_back(bit'((data >> i) & 1));
        if (pen) line.push_back(pb);
        line.push_back(s0);
        if (two) line.push_back(s1);
        for (int k = 0; k < line.size() && k < maxbits; k++) begin
            for (int c = 0; c < BIT_CLK; c++) begin
                @(negedge clk);
                rx = (k == spike && c >= 28 && c < 28 + TDIV) ? 1'b0 : line[k];
                if (scramble && k == 1 && c == 0) begin
                    data_bits   = 4'($urandom_range(0, 15));
                    parity_mode = 2'($urandom_range(0, 3));
                    stop_bits   = 1'($urandom_range(0, 1));
                end
            end
        end
        if (maxbits >= line.size()) begin
            @(negedge clk);
            rx = 1'b1;
            repeat (2 * BIT_CLK) @(negedge clk);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.rx_valid), 0);
        chk({tag, "_data"}, 32'(bus.rx_data), 0);
        chk({tag, "_pe"}, 32'(bus.parity_error), 0);
        chk({tag, "_fe"}, 32'(bus.framing_error), 0);
        chk({tag, "_brk"}, 32'(bus.break_detect), 0);
        chk({tag, "_ovr"}, 32'(bus.overrun_error), 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.rx_valid && bus.rx_ready) begin
            n_words++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h required none", bus.rx_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rx_data", 32'(bus.rx_data), 32'(e.data));
                chk("parity_error", 32'(bus.parity_error), 32'(e.pe));
                chk("framing_error", 32'(bus.framing_error), 32'(e.fe));
                chk("break_detect", 32'(bus.break_detect), 32'(e.bk));
            end
        end
    end

    initial begin
        int w;
        rx            = 1'b1;
        reset_n       = 1'b0;
        bus.rx_ready  = 1'b0;
        bus.err_clear = 1'b0;
        data_bits     = 4'd8;
        parity_mode   = 2'd0;
        stop_bits     = 1'b0;
        repeat (5) @(negedge clk);
        chk_outputs_zero("reset");
        reset_n      = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (BIT_CLK) @(negedge clk);

        w = n_words;
        frame(8, 0, 0, 'hA5, 0, 1, 1, 1, 99, -1, 0);
        chk("8n1_words", 32'(n_words - w), 1);

        frame(7, 1, 1, 'h55, 1, 1, 1, 1, 99, -1, 0);
        frame(7, 1, 1, 'h55, 0, 1, 1, 1, 99, -1, 0);

        data_bits   = 4'd8;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        w = n_words;
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * TDIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("false_start", 32'(n_words - w), 0);

        frame(8, 0, 0, 'h6B, 0, 1, 1, 1, 99, 4, 0);

        w = n_words;
        sb.push_back(model(8, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rx = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk);
        chk("break_one_word", 32'(n_words - w), 1);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        frame(8, 0, 0, 'h3C, 0, 1, 1, 1, 99, -1, 0);

        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
        frame(8, 0, 0, 'h11, 0, 1, 1, 1, 99, -1, 0);
        frame(8, 0, 0, 'h22, 0, 1, 1, 0, 99, -1, 0);
        chk("ovr_valid", 32'(bus.rx_valid), 1);
        chk("ovr_data", 32'(bus.rx_data), 'h11);
        chk("ovr_flag", 32'(bus.overrun_error), 1);
        w = n_words;
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_consumed", 32'(n_words - w), 1);
        chk("ovr_valid_low", 32'(bus.rx_valid), 0);
        chk("ovr_still_set", 32'(bus.overrun_error), 1);
        @(posedge clk);
        #1 bus.err_clear = 1'b1;
        @(posedge clk);
        #1 bus.err_clear = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", 32'(bus.overrun_error), 0);

        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
        frame(9, 2, 0, 'h1FF, 0, 1, 1, 0, 99, -1, 0);
        chk("9o1_valid", 32'(bus.rx_valid), 1);
        chk("9o1_data", 32'(bus.rx_data), 'h1FF);
        chk("9o1_pe", 32'(bus.parity_error), 0);
        chk("9o1_fe", 32'(bus.framing_error), 0);
        frame(9, 2, 0, 'h0AB, 0, 1, 1, 0, 5, -1, 0);
        @(negedge clk);
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (3) @(negedge clk);
        chk_outputs_zero("midreset");
        reset_n = 1'b1;
        @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        w = n_words;
        frame(9, 2, 0, 'h0F0, 0, 1, 1, 1, 99, -1, 0);
        chk("after_reset_word", 32'(n_words - w), 1);

        for (int i = 0; i < 25; i++) begin
            frame($urandom_range(0, 15), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 511),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 5) != 0, 1, 99, -1, 1);
        end

        repeat (BIT_CLK) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised next-generation UART receiver driven by an external oversampling tick.
- Frame format is runtime-configurable: 5..DATA_W data bits, none/even/odd parity, 1 or 2 stop bits.
- Adds an input synchroniser, 3-sample majority voting, framing/break/overrun detection and a ready/valid output holding register.
- Sits between the baud-tick generator and the RX FIFO or register interface.

Parameters:
- OVERSAMPLE, 16: sample_tick pulses per bit period; must be even and >= 8.
- DATA_W, 9: maximum data bits per frame; also the width of rx_data.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line; asynchronous to clk; idles high.
- sample_tick  in  1  one-clk pulse, OVERSAMPLE per bit period.
- data_bits  in  4  data bits per frame; values <5 are treated as 5, values >DATA_W as DATA_W.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- rx_ready  in  1  consumer accepts the held word.
- err_clear  in  1  clears overrun_error.
- rx_data  out  DATA_W  received word, right-aligned, unused MSBs zero.
- rx_valid  out  1  held word is valid.
- parity_error  out  1  per-word flag, meaningful while rx_valid=1.
- framing_error  out  1  per-word flag: a stop bit sampled as 0.
- break_detect  out  1  per-word flag: every bit of the frame, stop bit(s) included, sampled as 0.
- overrun_error  out  1  sticky flag: a completed frame was dropped.

Behaviour:
- Reset:
  - Async reset_n=0 clears every output to 0, sends the FSM to IDLE and clears all counters.
  - The 2-flop rx synchroniser resets to 1.
  - Reset mid-frame abandons the frame; no flag is raised.
- Synchronisation and timing:
  - All FSM sampling uses the synchronised rx (rx_s), which lags rx by 2 clk.
  - The FSM advances only on cycles where sample_tick=1.
  - Per-bit tick counter cnt runs 0..OVERSAMPLE-1; cnt=0 is the first tick of each bit.
- Voting: rx_s is sampled at cnt=M-1, M and M+1, where M=OVERSAMPLE/2. The bit value is the 2-of-3 majority, decided at cnt=M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - A tick with rx_s=0 and armed=1 goes to START with cnt=0.
    - data_bits (clamped), parity_mode and stop_bits are latched at this point; changes mid-frame have no effect.
    - armed is set by any tick with rx_s=1 and is cleared at the end of each frame.
  - START: voted bit 1 means a false start; return to IDLE and raise no flag. Voted bit 0 continues; at cnt=OVERSAMPLE-1 go to DATA.
  - DATA: the voted bit is shifted in LSB first. After the last data bit, at cnt=OVERSAMPLE-1, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: store the voted bit; at cnt=OVERSAMPLE-1 go to STOP.
  - STOP:
    - With two stop bits, the first is voted and checked, then the FSM waits for cnt=OVERSAMPLE-1.
    - The final stop bit completes the frame at its vote tick (cnt=M+1); the FSM then returns to IDLE so the next start bit can be caught.
    - The frame's framing_error is the OR of all stop-bit checks (any stop bit voted 0).
- Parity:
  - Expected bit is the XOR of the latched data bits (even) or its inverse (odd).
  - parity_error = received parity bit != expected bit. Forced 0 when parity is disabled.
- Break:
  - break_detect=1 when all data bits, the parity bit (if enabled) and the stop bit(s) are 0. framing_error is also 1 in that case.
  - Because armed is cleared, no new start bit is accepted until rx_s has been sampled high.
- Completion (registered on the same clk edge as the final stop vote):
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 that cycle: load rx_data and the three per-word flags, and set rx_valid=1.
  - Otherwise: the new frame is discarded, the held word is kept unchanged, and overrun_error is set.
- Handshake:
  - rx_valid&&rx_ready with no completion that cycle: rx_valid goes to 0 on the next edge.
  - rx_data and the flags are held until the word is consumed or replaced.
- err_clear=1 clears overrun_error next edge; a new overrun in the same cycle takes priority and overrun_error stays 1.
- Latency:
  - rx_valid rises 1 clk after the sample_tick carrying the final stop-bit vote.
  - That is about (1 + data_bits + parity + stops - 0.5) bit periods after the start edge, plus 2 clk for the synchroniser.

Test Plan:
- 8N1, OVERSAMPLE=16, byte 0xA5, rx_ready=1 -> rx_data=0x0A5, rx_valid pulses 1 clk, all flags 0.
- 7E2, send 0x55 with parity bit 1 (wrong; correct is 0) -> rx_data=0x055, parity_error=1. Repeat with correct parity -> parity_error=0.
- 8N1 with a 3-tick glitch on the start bit (low for 3 ticks only) -> false start, no rx_valid. A single-tick spike inside data bit 3 (value 1) -> rx_data bit 3 still 1.
- Hold rx=0 for 2 frame times, then release -> one word rx_data=0, framing_error=1, break_detect=1. No second word until rx is high, then a normal 0x3C is received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x011 and overrun_error=1. Then rx_ready=1 -> word consumed; err_clear -> overrun_error=0.
- 9O1 with DATA_W=9, send 0x1FF; assert reset_n=0 mid-data on another frame -> 0x1FF received correctly; after reset all outputs 0 and the next frame 0x0F0 is received correctly.
